// File: rtl/maquina_pkg.sv
// Shared vending-machine definitions: accumulator states, coin codes and the
// coin-value lookup used by the accumulator and the value-checker stage.
package maquina_pkg;

  localparam int LARGURA_VALOR = 4;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ACUMULANDO = 2'd1,
    DEVOLVENDO = 2'd2
  } estado_acum_t;

  localparam logic [1:0] MOEDA_NULA = 2'b00;
  localparam logic [1:0] MOEDA_1    = 2'b01;
  localparam logic [1:0] MOEDA_2    = 2'b10;
  localparam logic [1:0] MOEDA_5    = 2'b11;

  function automatic logic [LARGURA_VALOR-1:0] valor_moeda(input logic [1:0] code);
    logic [LARGURA_VALOR-1:0] valor;
    case (code)
      MOEDA_1: valor = LARGURA_VALOR'(1);
      MOEDA_2: valor = LARGURA_VALOR'(2);
      MOEDA_5: valor = LARGURA_VALOR'(5);
      default: valor = '0;
    endcase
    return valor;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: registers a level and pulses for the one cycle in
// which the level is high but was low at the previous clock edge.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  logic entrada_q;

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) entrada_q <= 1'b0;
    else       entrada_q <= entrada;
  end

  assign pulso = entrada & ~entrada_q;

endmodule

// File: rtl/acumulador_moedas.sv
// Coin accumulator: adds coin values into a saturating-by-rejection total,
// issues a one-cycle refund on cancel and clears the total on a completed sale.
module acumulador_moedas
  import maquina_pkg::*;
#(
  parameter int LARGURA   = 4,
  parameter int TOTAL_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               moeda_valida,
  input  logic [1:0]         moeda,
  input  logic               cancelar,
  input  logic               venda_ok,
  output logic [LARGURA-1:0] total,
  output logic               moeda_rejeitada,
  output logic               devolve,
  output logic [LARGURA-1:0] troco,
  output logic               cheio
);

  estado_acum_t       estado, estado_n;
  logic [LARGURA-1:0] total_n, troco_n;
  logic               rejeitada_n, devolve_n, cheio_n;
  logic               nova_moeda, moeda_real, cabe;
  logic [LARGURA:0]   soma;

  detector_borda u_borda_moeda (
    .clk     (clk),
    .reset   (reset),
    .entrada (moeda_valida),
    .pulso   (nova_moeda)
  );

  // Code 00 is not a coin at all: it neither accumulates nor gets rejected.
  assign moeda_real = nova_moeda & (moeda != MOEDA_NULA);
  // One extra bit so an oversized coin is detected instead of wrapping.
  assign soma = {1'b0, total} + (LARGURA+1)'(valor_moeda(moeda));
  assign cabe = (soma <= (LARGURA+1)'(TOTAL_MAX));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    estado_n    = estado;
    total_n     = total;
    troco_n     = troco;
    rejeitada_n = 1'b0;
    devolve_n   = 1'b0;

    case (estado)
      OCIOSO: begin
        if (cancelar || venda_ok) begin
          rejeitada_n = moeda_real;
        end else if (moeda_real) begin
          if (cabe) begin
            total_n  = soma[LARGURA-1:0];
            estado_n = ACUMULANDO;
          end else begin
            rejeitada_n = 1'b1;
          end
        end
      end

      ACUMULANDO: begin
        if (cancelar) begin
          troco_n     = total;
          total_n     = '0;
          devolve_n   = 1'b1;
          rejeitada_n = moeda_real;
          estado_n    = DEVOLVENDO;
        end else if (venda_ok) begin
          total_n     = '0;
          rejeitada_n = moeda_real;
          estado_n    = OCIOSO;
        end else if (moeda_real) begin
          if (cabe) total_n = soma[LARGURA-1:0];
          else      rejeitada_n = 1'b1;
        end
      end

      DEVOLVENDO: begin
        rejeitada_n = moeda_real;
        estado_n    = OCIOSO;
      end

      default: begin
        total_n  = '0;
        estado_n = OCIOSO;
      end
    endcase

    cheio_n = (total_n == LARGURA'(TOTAL_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= OCIOSO;
      total           <= '0;
      troco           <= '0;
      moeda_rejeitada <= 1'b0;
      devolve         <= 1'b0;
      cheio           <= 1'b0;
    end else begin
      estado          <= estado_n;
      total           <= total_n;
      troco           <= troco_n;
      moeda_rejeitada <= rejeitada_n;
      devolve         <= devolve_n;
      cheio           <= cheio_n;
    end
  end

endmodule

// File: tb/tb_acumulador_moedas.sv
// Directed self-checking bench for acumulador_moedas with hand-computed
// expected values, checked one cycle after each stimulus edge.
module tb_acumulador_moedas;
  import maquina_pkg::*;

  logic       clk = 1'b0;
  logic       reset, moeda_valida, cancelar, venda_ok;
  logic [1:0] moeda;
  logic [3:0] total, troco;
  logic       moeda_rejeitada, devolve, cheio;

  int n_cmp = 0;
  int n_err = 0;

  acumulador_moedas #(.LARGURA(4), .TOTAL_MAX(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .moeda_valida    (moeda_valida),
    .moeda           (moeda),
    .cancelar        (cancelar),
    .venda_ok        (venda_ok),
    .total           (total),
    .moeda_rejeitada (moeda_rejeitada),
    .devolve         (devolve),
    .troco           (troco),
    .cheio           (cheio)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_total, input logic e_rej,
                           input logic e_dev, input logic e_cheio, input estado_acum_t e_est);
    check({tag, ".total"}, 8'(total), 8'(e_total));
    check({tag, ".rejeitada"}, 8'(moeda_rejeitada), 8'(e_rej));
    check({tag, ".devolve"}, 8'(devolve), 8'(e_dev));
    check({tag, ".cheio"}, 8'(cheio), 8'(e_cheio));
    check({tag, ".estado"}, 8'(dut.estado), 8'(e_est));
  endtask

  // Raise the coin strobe for one cycle; caller checks the result, then drops it.
  task automatic coin_on(input logic [1:0] code);
    moeda = code;
    moeda_valida = 1'b1;
    step();
  endtask

  task automatic coin_off();
    moeda_valida = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; moeda_valida = 1'b0; moeda = 2'b00; cancelar = 1'b0; venda_ok = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);
    check("reset.troco", 8'(troco), 8'd0);

    // Coins 1, 2, 5 separated by low gaps.
    coin_on(MOEDA_1); check_all("c1", 4'd1, 1'b0, 1'b0, 1'b0, ACUMULANDO); coin_off();
    coin_on(MOEDA_2); check_all("c2", 4'd3, 1'b0, 1'b0, 1'b0, ACUMULANDO); coin_off();
    coin_on(MOEDA_5); check_all("c5", 4'd8, 1'b0, 1'b0, 1'b0, ACUMULANDO); coin_off();

    // Strobe held high for 5 cycles counts once.
    coin_on(MOEDA_2);
    check("held.first", 8'(total), 8'd10);
    for (int i = 0; i < 4; i++) step();
    check_all("held.end", 4'd10, 1'b0, 1'b0, 1'b0, ACUMULANDO);
    coin_off();

    // 10 + 2 = 12, then a 5 would overflow.
    coin_on(MOEDA_2); check("to12", 8'(total), 8'd12); coin_off();
    coin_on(MOEDA_5); check_all("ovf5", 4'd12, 1'b1, 1'b0, 1'b0, ACUMULANDO);
    coin_off();       check_all("ovf5.after", 4'd12, 1'b0, 1'b0, 1'b0, ACUMULANDO);
    coin_on(MOEDA_2); check_all("to14", 4'd14, 1'b0, 1'b0, 1'b0, ACUMULANDO); coin_off();
    coin_on(MOEDA_1); check_all("to15", 4'd15, 1'b0, 1'b0, 1'b1, ACUMULANDO); coin_off();
    coin_on(MOEDA_1); check_all("ovf1", 4'd15, 1'b1, 1'b0, 1'b1, ACUMULANDO); coin_off();

    // Completed sale clears the total.
    venda_ok = 1'b1; step();
    check_all("venda", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);
    venda_ok = 1'b0;

    // Build 8 and cancel for 3 cycles: one refund only.
    coin_on(MOEDA_5); coin_off();
    coin_on(MOEDA_2); coin_off();
    coin_on(MOEDA_1); check("to8", 8'(total), 8'd8); coin_off();
    cancelar = 1'b1;
    step(); check_all("cancel.n", 4'd0, 1'b0, 1'b1, 1'b0, DEVOLVENDO);
    check("cancel.troco", 8'(troco), 8'd8);
    step(); check_all("cancel.n1", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);
    check("cancel.troco_held", 8'(troco), 8'd8);
    step(); check_all("cancel.n2", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);
    cancelar = 1'b0;

    // Sale and coin edge in the same cycle: coin rejected, total cleared.
    coin_on(MOEDA_5); check("to5", 8'(total), 8'd5); coin_off();
    venda_ok = 1'b1; moeda = MOEDA_1; moeda_valida = 1'b1;
    step(); check_all("venda_coin", 4'd0, 1'b1, 1'b0, 1'b0, OCIOSO);
    venda_ok = 1'b0; moeda_valida = 1'b0;
    step(); check_all("venda_coin.after", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);

    // Coin arriving during the refund cycle is rejected.
    coin_on(MOEDA_1); coin_off();
    cancelar = 1'b1; step();
    check("refund1.troco", 8'(troco), 8'd1);
    cancelar = 1'b0; moeda = MOEDA_2; moeda_valida = 1'b1;
    step(); check_all("coin_in_refund", 4'd0, 1'b1, 1'b0, 1'b0, OCIOSO);
    coin_off();

    // Reset during the refund cycle aborts the pulse.
    coin_on(MOEDA_2); coin_off();
    cancelar = 1'b1; step();
    check("pre_rst.devolve", 8'(devolve), 8'd1);
    check("pre_rst.troco", 8'(troco), 8'd2);
    cancelar = 1'b0; reset = 1'b1;
    step(); check_all("rst_refund", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO);
    check("rst_refund.troco", 8'(troco), 8'd0);
    reset = 1'b0;

    // Code 00 edge is ignored entirely.
    coin_on(MOEDA_NULA); check_all("code00", 4'd0, 1'b0, 1'b0, 1'b0, OCIOSO); coin_off();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
